lfsr_prbs_ctrl: RTL and testbench
=================================

LFSR_PRBS_CTRL -- requirements
Module: lfsr_prbs_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of generator words and of the output stream; it SHALL match OUTPUT_WIDTH of the driven lfsr_prbs.
REQ-002 Parameter COUNT_WIDTH, default 32: width of the burst length and word counters.
REQ-003 Parameter ERR_WIDTH, default 32: width of the error counters.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  single-cycle command to begin a burst; honoured only in IDLE.
REQ-007 stop  input  1  single-cycle command to abort a burst in progress.
REQ-008 burst_len  input  COUNT_WIDTH  number of words per burst, sampled on the start cycle; 0 means continuous.
REQ-009 gen_rst  output  1  reseed pulse to the generator's rst.
REQ-010 gen_enable  output  1  advance pulse to the generator's enable.
REQ-011 gen_data  input  DATA_WIDTH  current generator word.
REQ-012 m_tdata / m_tvalid / m_tready / m_tlast  out/out/in/out  DATA_WIDTH/1/1/1  output stream.
REQ-013 err_in  input  DATA_WIDTH  per-bit mismatch flags from the PRBS checker.
REQ-014 err_valid  input  1  qualifies err_in.
REQ-015 busy / done  output  1 / 1  burst active; one-cycle completion pulse.
REQ-016 word_count  output  COUNT_WIDTH  words accepted on the stream this burst.
REQ-017 bit_err_count / word_err_count  output  ERR_WIDTH each  accumulated bit and word errors.

Function
REQ-018 The FSM SHALL have four states: IDLE, SEED, RUN and FLUSH.
REQ-019 IDLE + start: latch burst_len, clear word_count and both error counters, and go to SEED.
REQ-020 SEED SHALL last exactly one cycle, drive gen_rst=1, and then go to RUN; gen_rst SHALL be 0 in every other state.
REQ-021 load = (state==RUN) && (!m_tvalid || m_tready) && (remaining != 0 || continuous); gen_enable SHALL equal load combinationally.
REQ-022 On load, m_tdata <= gen_data and m_tvalid <= 1, giving one cycle of latency from gen_data to m_tdata.
REQ-023 On m_tvalid && m_tready with no load, m_tvalid SHALL go to 0.
REQ-024 Once asserted, m_tvalid SHALL NOT deassert and m_tdata SHALL NOT change until the word is accepted.
REQ-025 The remaining counter SHALL decrement on each load.
REQ-026 m_tlast SHALL be 1 on the word loaded when remaining==1; it SHALL be 0 for the whole of a continuous burst.
REQ-027 RUN goes to FLUSH when the final word is loaded, or when stop is asserted.
REQ-028 In FLUSH, no further loads occur; the state goes to IDLE and done is pulsed on the cycle in which m_tvalid is 0 or the held word is accepted.
REQ-029 A word held at stop SHALL still be delivered, with m_tlast=1 forced on it.
REQ-030 stop in IDLE is ignored; start outside IDLE is ignored; stop has priority over final-word completion in the same cycle, with identical effect.
REQ-031 word_count SHALL increment on every stream handshake and saturate at all-ones.
REQ-032 While err_valid=1, bit_err_count += popcount(err_in) and word_err_count += (err_in != 0); both SHALL saturate at all-ones without wrap.
REQ-033 Error accumulation SHALL continue in every state, so late checker results after done are still counted.
REQ-034 The error counters SHALL clear only on start or reset.
REQ-035 busy = (state != IDLE).

Reset
REQ-036 Asserting rst SHALL immediately force state IDLE, and m_tvalid, m_tlast, gen_enable, done, busy, word_count, bit_err_count, word_err_count and remaining to 0; m_tdata SHALL reset to 0.
REQ-037 gen_rst SHALL be 0 while rst is asserted; the generator has its own system reset.
REQ-038 A rst asserted mid-burst SHALL abandon the burst with no done pulse; the first burst after reset SHALL again pass through SEED.

Verification
REQ-039 burst_len=4, m_tready=1 -> exactly 4 handshakes matching the first 4 PRBS words after reseed, m_tlast on the 4th, done one cycle after the 4th handshake.
REQ-040 burst_len=3, m_tready toggling 1,0,0,1,... -> m_tdata stable while stalled, 3 words with no duplicates or skips, gen_enable pulsed exactly 3 times.
REQ-041 burst_len=0, stop after 10 handshakes with a word held and m_tready=0 -> held word delivered with m_tlast=1, word_count=11, done pulse.
REQ-042 err_valid with err_in=8'hA5, then 8'h00, then 8'h01 -> bit_err_count=5, word_err_count=2; ERR_WIDTH=4 with 20 single-bit errors -> saturates at 15.
REQ-043 rst asserted mid-RUN -> all outputs 0 asynchronously; next start -> gen_rst pulse, then the sequence restarts from the seed word.
REQ-044 start during RUN and stop during IDLE -> no state change and the counters are unaffected.

Source files
------------

// File: rtl/lfsr_prbs_ctrl.sv
// Burst controller for an external PRBS generator: reseeds it, streams its words out with
// valid/ready/last handshaking, and accumulates checker bit and word error counts.
module lfsr_prbs_ctrl #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned ERR_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [COUNT_WIDTH-1:0] burst_len,
    output logic                   gen_rst,
    output logic                   gen_enable,
    input  logic [DATA_WIDTH-1:0]  gen_data,
    output logic [DATA_WIDTH-1:0]  m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    input  logic [DATA_WIDTH-1:0]  err_in,
    input  logic                   err_valid,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] word_count,
    output logic [ERR_WIDTH-1:0]   bit_err_count,
    output logic [ERR_WIDTH-1:0]   word_err_count
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StSeed  = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;
    localparam logic [1:0] StFlush = 2'd3;

    localparam int unsigned PopWidth = $clog2(DATA_WIDTH + 1);
    localparam int unsigned SumWidth = ((ERR_WIDTH > PopWidth) ? ERR_WIDTH : PopWidth) + 1;
    localparam logic [SumWidth-1:0] ErrMax = SumWidth'({ERR_WIDTH{1'b1}});

    logic [1:0]             state;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   continuous;
    logic                   load;
    logic                   last_load;
    logic                   handshake;
    logic [PopWidth-1:0]    err_pop;
    logic [SumWidth-1:0]    bit_sum;
    logic [SumWidth-1:0]    word_sum;

    assign handshake  = m_tvalid && m_tready;
    assign load       = (state == StRun) && (!m_tvalid || m_tready) &&
                        ((remaining != '0) || continuous);
    assign last_load  = !continuous && (remaining == COUNT_WIDTH'(1));
    assign gen_enable = load;
    assign gen_rst    = (state == StSeed);
    assign busy       = (state != StIdle);

    always_comb begin
        err_pop = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            err_pop = err_pop + PopWidth'(err_in[i]);
        end
    end

    // Sums are one bit wider than the counters so overflow is visible for saturation.
    assign bit_sum  = SumWidth'(bit_err_count) + SumWidth'(err_pop);
    assign word_sum = SumWidth'(word_err_count) + SumWidth'(err_in != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            remaining  <= '0;
            continuous <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        remaining  <= burst_len;
                        continuous <= (burst_len == '0);
                        state      <= StSeed;
                    end
                end
                StSeed: state <= StRun;
                StRun: begin
                    if (load && !continuous) begin
                        remaining <= remaining - COUNT_WIDTH'(1);
                    end
                    if (stop || (load && last_load)) begin
                        state <= StFlush;
                    end
                end
                StFlush: begin
                    if (!m_tvalid || m_tready) begin
                        state <= StIdle;
                        done  <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // A stop that finds a word stalled on the bus marks that word as the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else if (load) begin
            m_tdata  <= gen_data;
            m_tvalid <= 1'b1;
            m_tlast  <= stop || last_load;
        end else if (handshake) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else if ((state == StRun) && stop) begin
            m_tlast <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count     <= '0;
            bit_err_count  <= '0;
            word_err_count <= '0;
        end else if ((state == StIdle) && start) begin
            word_count     <= '0;
            bit_err_count  <= '0;
            word_err_count <= '0;
        end else begin
            if (handshake && (word_count != '1)) begin
                word_count <= word_count + COUNT_WIDTH'(1);
            end
            if (err_valid) begin
                bit_err_count  <= (bit_sum > ErrMax) ? '1 : bit_sum[ERR_WIDTH-1:0];
                word_err_count <= (word_sum > ErrMax) ? '1 : word_sum[ERR_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_lfsr_prbs_ctrl.sv
// Bench for lfsr_prbs_ctrl: an 8-bit LFSR stands in for the generator, a queue holds the
// words each burst should deliver, and a negedge monitor compares every stream handshake.
module tb_lfsr_prbs_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 32;
    localparam int unsigned EW = 32;
    localparam logic [7:0] SEED = 8'h01;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        logic [7:0] err;
        logic       vld;
        int         exp_bit;
        int         exp_word;
    } err_vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          gen_sys_rst;
    logic          start;
    logic          stop;
    logic [CW-1:0] burst_len;
    logic          gen_rst;
    logic          gen_enable;
    logic [DW-1:0] gen_data;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [DW-1:0] err_in;
    logic          err_valid;
    logic          busy;
    logic          done;
    logic [CW-1:0] word_count;
    logic [EW-1:0] bit_err_count;
    logic [EW-1:0] word_err_count;

    logic [DW-1:0] sat_err_in;
    logic          sat_err_valid;
    logic          sat_gen_rst;
    logic          sat_gen_enable;
    logic [DW-1:0] sat_m_tdata;
    logic          sat_m_tvalid;
    logic          sat_m_tlast;
    logic          sat_busy;
    logic          sat_done;
    logic [CW-1:0] sat_word_count;
    logic [3:0]    sat_bit_err_count;
    logic [3:0]    sat_word_err_count;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   en_cnt = 0;
    int   grst_cnt = 0;
    int   done_cnt = 0;
    int   hs_cyc = 0;
    int   done_cyc = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] lfsr;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    lfsr_prbs_ctrl #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .ERR_WIDTH(EW)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .burst_len      (burst_len),
        .gen_rst        (gen_rst),
        .gen_enable     (gen_enable),
        .gen_data       (gen_data),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tlast        (m_tlast),
        .err_in         (err_in),
        .err_valid      (err_valid),
        .busy           (busy),
        .done           (done),
        .word_count     (word_count),
        .bit_err_count  (bit_err_count),
        .word_err_count (word_err_count)
    );

    lfsr_prbs_ctrl #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .ERR_WIDTH(4)) u_sat (
        .clk            (clk),
        .rst            (rst),
        .start          (1'b0),
        .stop           (1'b0),
        .burst_len      ('0),
        .gen_rst        (sat_gen_rst),
        .gen_enable     (sat_gen_enable),
        .gen_data       ('0),
        .m_tdata        (sat_m_tdata),
        .m_tvalid       (sat_m_tvalid),
        .m_tready       (1'b1),
        .m_tlast        (sat_m_tlast),
        .err_in         (sat_err_in),
        .err_valid      (sat_err_valid),
        .busy           (sat_busy),
        .done           (sat_done),
        .word_count     (sat_word_count),
        .bit_err_count  (sat_bit_err_count),
        .word_err_count (sat_word_err_count)
    );

    function automatic logic [7:0] prbs_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Generator model; only its own system reset or gen_rst returns it to the seed.
    always @(posedge clk or posedge gen_sys_rst) begin
        if (gen_sys_rst)     lfsr <= SEED;
        else if (gen_rst)    lfsr <= SEED;
        else if (gen_enable) lfsr <= prbs_next(lfsr);
    end
    assign gen_data = lfsr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n, input logic last_on_final);
        logic [7:0] s;
        exp_t x;
        s = SEED;
        for (int i = 0; i < n; i++) begin
            x.data = s;
            x.last = last_on_final && (i == n - 1);
            sb.push_back(x);
            s = prbs_next(s);
        end
    endtask

    task automatic wait_done(input int max_cycles, input string name);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < max_cycles && done_cnt == d0; i++) tick();
        check(name, 64'(done_cnt - d0), 64'd1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(m_tvalid), 64'd1);
                check("stall_data", 64'(m_tdata), 64'(prev_data));
            end
            if (gen_enable) en_cnt++;
            if (gen_rst) grst_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (m_tvalid && m_tready) begin
                hs_cnt++;
                hs_cyc = cyc;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_extra_word: got %0h, expected no word", m_tdata);
                end else begin
                    e = sb.pop_front();
                    check("tdata", 64'(m_tdata), 64'(e.data));
                    check("tlast", 64'(m_tlast), 64'(e.last));
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        err_vec_t tbl[5];
        logic [3:0] rdy_pat;
        int en0, g0, d0, h0;

        tbl[0] = '{8'hA5, 1'b1, 4, 1};
        tbl[1] = '{8'h00, 1'b1, 4, 1};
        tbl[2] = '{8'h01, 1'b1, 5, 2};
        tbl[3] = '{8'hFF, 1'b0, 5, 2};
        tbl[4] = '{8'hFF, 1'b1, 13, 3};
        rdy_pat = 4'b1001;

        rst = 1'b1; gen_sys_rst = 1'b1; start = 1'b0; stop = 1'b0; burst_len = '0;
        m_tready = 1'b0; err_in = '0; err_valid = 1'b0; sat_err_in = '0; sat_err_valid = 1'b0;
        #2;
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tlast", 64'(m_tlast), 64'd0);
        check("rst_tdata", 64'(m_tdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_gen_rst", 64'(gen_rst), 64'd0);
        check("rst_gen_en", 64'(gen_enable), 64'd0);
        check("rst_wcount", 64'(word_count), 64'd0);
        check("rst_bit_err", 64'(bit_err_count), 64'd0);
        check("rst_word_err", 64'(word_err_count), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; gen_sys_rst = 1'b0;
        tick();

        // Four-word burst at full rate.
        push_words(4, 1'b1);
        en0 = en_cnt; g0 = grst_cnt;
        m_tready = 1'b1; burst_len = 4; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(40, "b4_done");
        check("b4_done_latency", 64'(done_cyc), 64'(hs_cyc + 1));
        check("b4_wcount", 64'(word_count), 64'd4);
        check("b4_gen_en", 64'(en_cnt - en0), 64'd4);
        check("b4_gen_rst", 64'(grst_cnt - g0), 64'd1);
        check("b4_sb_empty", 64'(sb.size()), 64'd0);
        check("b4_idle", 64'(busy), 64'd0);

        // Error accumulation after done, table driven.
        for (int i = 0; i < 5; i++) begin
            err_in = tbl[i].err; err_valid = tbl[i].vld;
            tick();
            check("err_bit", 64'(bit_err_count), 64'(tbl[i].exp_bit));
            check("err_word", 64'(word_err_count), 64'(tbl[i].exp_word));
        end
        err_valid = 1'b0; err_in = '0;

        // Four-bit counters saturate.
        sat_err_in = 8'h10; sat_err_valid = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("sat_bit_14", 64'(sat_bit_err_count), 64'd14);
        end
        sat_err_valid = 1'b0;
        check("sat_bit", 64'(sat_bit_err_count), 64'd15);
        check("sat_word", 64'(sat_word_err_count), 64'd15);

        // Three words under a 1,0,0,1 ready pattern; a start mid-burst is ignored.
        push_words(3, 1'b1);
        en0 = en_cnt; d0 = done_cnt;
        m_tready = 1'b1; burst_len = 3; start = 1'b1;
        tick();
        start = 1'b0;
        check("start_clr_bit", 64'(bit_err_count), 64'd0);
        check("start_clr_word", 64'(word_err_count), 64'd0);
        for (int i = 0; i < 60 && done_cnt == d0; i++) begin
            m_tready = rdy_pat[i % 4];
            start = (i == 4);
            burst_len = (i == 4) ? 7 : 3;
            tick();
        end
        start = 1'b0; m_tready = 1'b1;
        check("b3_done", 64'(done_cnt - d0), 64'd1);
        check("b3_wcount", 64'(word_count), 64'd3);
        check("b3_gen_en", 64'(en_cnt - en0), 64'd3);
        check("b3_sb_empty", 64'(sb.size()), 64'd0);

        // Stop in IDLE does nothing.
        d0 = done_cnt;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("idle_stop_busy", 64'(busy), 64'd0);
        check("idle_stop_wcount", 64'(word_count), 64'd3);
        check("idle_stop_done", 64'(done_cnt - d0), 64'd0);

        // Continuous burst stopped with the eleventh word stalled on the bus.
        push_words(11, 1'b1);
        m_tready = 1'b1; burst_len = 0; start = 1'b1;
        tick();
        start = 1'b0;
        h0 = hs_cnt;
        for (int i = 0; i < 100 && (hs_cnt - h0) < 10; i++) tick();
        m_tready = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check("cont_held_valid", 64'(m_tvalid), 64'd1);
        check("cont_held_last", 64'(m_tlast), 64'd1);
        check("cont_busy", 64'(busy), 64'd1);
        m_tready = 1'b1;
        wait_done(20, "cont_done");
        check("cont_wcount", 64'(word_count), 64'd11);
        check("cont_hs", 64'(hs_cnt - h0), 64'd11);
        check("cont_sb_empty", 64'(sb.size()), 64'd0);

        // Reset mid-run abandons the burst; the next burst reseeds.
        push_words(20, 1'b1);
        burst_len = 20; m_tready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        d0 = done_cnt; g0 = grst_cnt;
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
        check("mid_rst_tdata", 64'(m_tdata), 64'd0);
        check("mid_rst_tlast", 64'(m_tlast), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_gen_en", 64'(gen_enable), 64'd0);
        check("mid_rst_gen_rst", 64'(gen_rst), 64'd0);
        check("mid_rst_wcount", 64'(word_count), 64'd0);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        push_words(2, 1'b1);
        burst_len = 2; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(30, "post_rst_done");
        check("post_rst_gen_rst", 64'(grst_cnt - g0), 64'd1);
        check("post_rst_wcount", 64'(word_count), 64'd2);
        check("post_rst_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
